avalon_bus_arbiter: RTL and testbench

- Shares the single Avalon-MM master port of mips_cpu_bus between two CPU-side requesters: instruction fetch (read-only) and data load/store.
- Sequences each access on the bus and holds it stable across waitrequest.
- Returns a one-cycle ack with captured readdata to the requester that was granted.
- Sits between the CPU core datapath and the top-level bus pins.

---
 rtl/mips_bus_pkg.sv | 21 ++
 rtl/avalon_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_avalon_bus_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types for the mips_cpu_bus Avalon arbiter.
// State, port and byte-lane constants.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS_I,
    BUS_D
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

  // Applied to the byte-offset bits: the bus address is always word aligned.
  localparam logic [1:0] WORD_MASK = 2'b00;

endpackage

// File: rtl/avalon_bus_arbiter.sv
// Arbitrates fetch and data requesters onto one Avalon-MM master port.
// All bus strobes and requester responses are registered.
module avalon_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int DATA_PRIORITY = 0,
  parameter int ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_byteenable,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [31:0]       writedata,
  input  logic              waitrequest,
  input  logic [31:0]       readdata
);

  arb_state_t r_state;
  arb_state_t w_next;
  port_t      r_last;

  logic w_i_elig;
  logic w_d_elig;
  logic w_gnt_i;
  logic w_gnt_d;
  logic w_done;

  // Grant decision and next state; ack cycle blocks a re-issue.
  always_comb begin
    w_i_elig = i_req && !i_ack;
    w_d_elig = d_req && !d_ack;
    w_next   = r_state;
    w_gnt_i  = 1'b0;
    w_gnt_d  = 1'b0;
    w_done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_i_elig && w_d_elig) begin
          if (DATA_PRIORITY != 0 || r_last == PORT_I)
            w_gnt_d = 1'b1;
          else
            w_gnt_i = 1'b1;
        end else if (w_i_elig) begin
          w_gnt_i = 1'b1;
        end else if (w_d_elig) begin
          w_gnt_d = 1'b1;
        end
        if (w_gnt_i) w_next = BUS_I;
        if (w_gnt_d) w_next = BUS_D;
      end
      BUS_I, BUS_D: begin
        if (!waitrequest) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= PORT_D;
    end else begin
      r_state <= w_next;
      if (w_gnt_i) r_last <= PORT_I;
      if (w_gnt_d) r_last <= PORT_D;
    end
  end

  // Bus strobes latched at grant, held through stalls, cleared on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      byteenable <= 4'b0000;
      writedata  <= 32'h0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= 32'h0;
      d_rdata    <= 32'h0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      if (w_gnt_i) begin
        address    <= {i_addr[ADDR_W-1:2], i_addr[1:0] & WORD_MASK};
        read       <= 1'b1;
        write      <= 1'b0;
        byteenable <= BE_WORD;
        writedata  <= 32'h0;
      end else if (w_gnt_d) begin
        address    <= {d_addr[ADDR_W-1:2], d_addr[1:0] & WORD_MASK};
        read       <= !d_write;
        write      <= d_write;
        byteenable <= d_byteenable;
        writedata  <= d_write ? d_wdata : 32'h0;
      end else if (w_done) begin
        read       <= 1'b0;
        write      <= 1'b0;
        byteenable <= 4'b0000;
        if (r_state == BUS_I) begin
          i_ack   <= 1'b1;
          i_rdata <= readdata;
        end else begin
          d_ack <= 1'b1;
          if (read) d_rdata <= readdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Scoreboard bench for avalon_bus_arbiter with a stalling slave model.
// A second instance with DATA_PRIORITY=1 checks the fixed-priority tie.
module tb_avalon_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 0, d_req = 0, d_write = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic [3:0]  d_byteenable = 0;
  logic        i_ack, d_ack, read, write;
  logic [31:0] i_rdata, d_rdata, address, writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 0;
  logic [31:0] readdata = 0;

  logic        p_i_req = 0, p_d_req = 0;
  logic [31:0] p_i_addr = 0, p_d_addr = 0;
  logic        p_i_ack, p_d_ack, p_read, p_write;
  logic [31:0] p_i_rdata, p_d_rdata, p_address, p_writedata;
  logic [3:0]  p_byteenable;

  always #5 clk = ~clk;

  avalon_bus_arbiter u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .address(address), .read(read),
    .write(write), .byteenable(byteenable),
    .writedata(writedata),
    .waitrequest(waitrequest),
    .readdata(readdata)
  );

  avalon_bus_arbiter #(.DATA_PRIORITY(1)) u_pri (
    .clk(clk), .reset(reset),
    .i_req(p_i_req), .i_addr(p_i_addr),
    .i_ack(p_i_ack), .i_rdata(p_i_rdata),
    .d_req(p_d_req), .d_write(1'b0),
    .d_addr(p_d_addr), .d_wdata(32'h0),
    .d_byteenable(4'hF),
    .d_ack(p_d_ack), .d_rdata(p_d_rdata),
    .address(p_address), .read(p_read),
    .write(p_write), .byteenable(p_byteenable),
    .writedata(p_writedata),
    .waitrequest(1'b0),
    .readdata(32'h1234_5678)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  int   order[$];
  int   stall_cfg = 0;
  int   wcnt = 0;
  logic [31:0] d_last = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h8C01_0064;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  logic [69:0] s_vec;
  int          s_cyc = 0;
  logic        s_stable = 1;
  logic [69:0] done_vec = 0;
  int          done_cyc = 0;
  logic        done_stable = 0;

  task automatic check_done(input string p, input exp_t e,
                            input logic [31:0] rd);
    chk({p, "_addr"}, done_vec[69:38], e.addr);
    chk({p, "_read"}, {31'b0, done_vec[37]}, {31'b0, !e.wr});
    chk({p, "_write"}, {31'b0, done_vec[36]}, {31'b0, e.wr});
    chk({p, "_be"}, {28'b0, done_vec[35:32]}, {28'b0, e.be});
    chk({p, "_wdata"}, done_vec[31:0], e.wdata);
    chk({p, "_cycles"}, done_cyc, e.cyc);
    chk({p, "_stable"}, {31'b0, done_stable}, 32'd1);
    chk({p, "_rdata"}, rd, e.rdata);
  endtask

  // Ack scoreboard, then slave response and bus monitor.
  always @(negedge clk) begin
    exp_t e;
    if (i_ack || d_ack)
      chk("ack_overlap", {31'b0, i_ack & d_ack}, 32'd0);
    if (i_ack) begin
      order.push_back(0);
      if (iq.size() == 0) chk("i_spurious", 1, 0);
      else begin
        e = iq.pop_front();
        check_done("i", e, i_rdata);
      end
    end
    if (d_ack) begin
      order.push_back(1);
      if (dq.size() == 0) chk("d_spurious", 1, 0);
      else begin
        e = dq.pop_front();
        check_done("d", e, d_rdata);
      end
    end
    if (reset || !(read || write)) begin
      waitrequest = 0;
      wcnt = 0;
      s_cyc = 0;
      readdata = 32'hDEAD_BEEF;
    end else begin
      if (s_cyc == 0) begin
        s_vec = {address, read, write, byteenable, writedata};
        s_stable = 1;
      end else if ({address, read, write, byteenable, writedata} !== s_vec) begin
        s_stable = 0;
      end
      s_cyc++;
      if (wcnt < stall_cfg) begin
        waitrequest = 1;
        readdata = 32'hDEAD_BEEF;
        wcnt++;
      end else begin
        waitrequest = 0;
        readdata = mem(address);
        done_vec = s_vec;
        done_cyc = s_cyc;
        done_stable = s_stable;
      end
    end
  end

  task automatic fetch(input logic [31:0] a, output int lat);
    exp_t e;
    e.addr = {a[31:2], 2'b00};
    e.wr = 0; e.be = 4'hF; e.wdata = 0;
    e.rdata = mem(e.addr);
    e.cyc = stall_cfg + 1;
    iq.push_back(e);
    @(posedge clk); #1;
    i_req = 1; i_addr = a;
    lat = 0;
    do begin @(negedge clk); lat++; end
    while (!i_ack && lat < 200);
    if (!i_ack) chk("i_timeout", 0, 1);
    i_req = 0;
  endtask

  task automatic data(input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic wig, output int lat);
    exp_t e;
    e.addr = {a[31:2], 2'b00};
    e.wr = wr; e.be = be;
    e.wdata = wr ? wd : 32'h0;
    e.rdata = wr ? d_last : mem(e.addr);
    if (!wr) d_last = e.rdata;
    e.cyc = stall_cfg + 1;
    dq.push_back(e);
    @(posedge clk); #1;
    d_req = 1; d_write = wr; d_addr = a;
    d_wdata = wd; d_byteenable = be;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (wig && lat == 2) begin
        d_addr = ~a; d_wdata = ~wd; d_byteenable = ~be;
      end
    end while (!d_ack && lat < 200);
    if (!d_ack) chk("d_timeout", 0, 1);
    d_req = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    d_last = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    logic got_i;
    logic [31:0] ra;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_read", {31'b0, read}, 0);
    chk("rst_write", {31'b0, write}, 0);
    chk("rst_be", {28'b0, byteenable}, 0);
    chk("rst_addr", address, 0);
    chk("rst_wdata", writedata, 0);
    chk("rst_iack", {31'b0, i_ack}, 0);
    chk("rst_dack", {31'b0, d_ack}, 0);
    chk("rst_irdata", i_rdata, 0);
    chk("rst_drdata", d_rdata, 0);

    // fixed data priority on a tie
    @(posedge clk); #1;
    p_i_req = 1; p_d_req = 1;
    p_i_addr = 32'h100; p_d_addr = 32'h200;
    n = 0;
    while (!p_read && n < 10) begin @(negedge clk); n++; end
    chk("prio_first_addr", p_address, 32'h200);
    got_i = 0;
    n = 0;
    while (!got_i && n < 20) begin
      @(negedge clk); n++;
      if (p_d_ack) p_d_req = 0;
      if (p_i_ack) begin
        got_i = 1;
        chk("prio_i_rdata", p_i_rdata, 32'h1234_5678);
      end
    end
    p_i_req = 0;
    chk("prio_i_done", {31'b0, got_i}, 1);

    stall_cfg = 0;
    fetch(32'hBFC0_0000, lat);
    chk("fetch_lat", lat, 3);
    chk("fetch_rd_off", {31'b0, read}, 0);

    stall_cfg = 3;
    data(0, 32'h190, 32'h0, 4'hF, 1, lat);
    chk("stall_lat", lat, 6);

    stall_cfg = 0;
    data(1, 32'h323, 32'hDD00_0000, 4'b1000, 0, lat);
    chk("store_lat", lat, 3);

    data(0, 32'h44, 32'h0, 4'b0000, 0, lat);
    chk("be0_lat", lat, 3);

    for (int k = 0; k < 6; k++) begin
      stall_cfg = $urandom_range(0, 2);
      ra = $urandom;
      if (k % 3 == 0) fetch(ra, lat);
      else if (k % 3 == 1)
        data(0, ra, 32'h0, 4'($urandom_range(0, 15)), 0, lat);
      else
        data(1, ra, $urandom, 4'($urandom_range(0, 15)), 0, lat);
      chk("rand_lat", lat, stall_cfg + 3);
    end

    // round-robin contention from reset
    do_reset();
    stall_cfg = 0;
    order.delete();
    fork
      begin
        int l1;
        for (int k = 0; k < 3; k++) fetch(32'h1000 + k * 4, l1);
      end
      begin
        int l2;
        for (int k = 0; k < 3; k++)
          data(0, 32'h2000 + k * 4, 32'h0, 4'hF, 0, l2);
      end
    join
    @(negedge clk);
    chk("rr_count", order.size(), 6);
    for (int k = 0; k < 6 && k < order.size(); k++)
      chk($sformatf("rr_order%0d", k), order[k], k % 2);

    // reset in the middle of a stalled load
    stall_cfg = 20;
    @(posedge clk); #1;
    d_req = 1; d_write = 0; d_addr = 32'h300; d_byteenable = 4'hF;
    n = 0;
    while (!read && n < 10) begin @(negedge clk); n++; end
    chk("mid_read_up", {31'b0, read}, 1);
    #2 reset = 1;
    #1;
    chk("mid_read", {31'b0, read}, 0);
    chk("mid_write", {31'b0, write}, 0);
    chk("mid_be", {28'b0, byteenable}, 0);
    d_req = 0;
    d_last = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    stall_cfg = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_no_ack", {31'b0, d_ack}, 0);
    end
    data(0, 32'h300, 32'h0, 4'hF, 0, lat);
    chk("rereq_lat", lat, 3);

    repeat (3) @(negedge clk);
    chk("iq_empty", iq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
